pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is a flat DATA_W bus.
- Replaces the global-enable stage registers. It uses a valid/ready handshake with a 2-entry skid buffer, so ready is registered and no combinational ready chain runs through the pipeline.
- Supports a synchronous flush that kills all held entries and emits a one-cycle flush marker downstream. A saturating stall counter supports performance debug.

Parameters:
- DATA_W, 128, payload width in bits (packed control + operands).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload driven on out_data whenever out_valid=0 (e.g. NOP encoding).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict / trap).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  output payload; BUBBLE_VAL when out_valid=0.
- out_flushed  out  1  one-cycle marker, high the cycle after a flush.
- occupancy  out  2  entries held (0..2).
- stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each with its own valid bit.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !rst & !flush & !skid_valid. The skid_valid term is registered; flush/rst gating is the only combinational path.
- Priority per cycle: rst > flush > normal update.
- rst: main_valid=0, skid_valid=0, out_data=BUBBLE_VAL, out_flushed=0, occupancy=0, stall_count=0. in_ready=0 while rst is high and 1 on the first cycle after.
- flush (rst low):
  - Next cycle: main_valid=0, skid_valid=0, out_data=BUBBLE_VAL, out_flushed=1.
  - in_data in the flush cycle is dropped; in_ready=0 in that cycle.
  - An out_fire in the flush cycle still completes; downstream owns squashing that entry.
- out_flushed is 0 in every cycle not immediately following a flush. Back-to-back flushes hold it at 1.
- Normal update (no rst/flush):
  - Main empty, in_fire: load main next cycle. Latency is 1 cycle.
  - Main full, out_fire, in_fire: main <= in_data. Throughput is 1/cycle.
  - Main full, out_fire, no in_fire, skid empty: main_valid <= 0.
  - Main full, no out_fire, in_fire: skid <= in_data, skid_valid <= 1. in_ready drops next cycle.
  - Skid full, out_fire: main <= skid, skid_valid <= 0. No in_fire is possible (in_ready=0).
  - Skid full, no out_fire: hold everything.
- Ordering is strictly FIFO. Payload is never duplicated or lost except by flush.
- When main_valid=0, out_data=BUBBLE_VAL; the main data register is loaded with BUBBLE_VAL whenever it empties.
- occupancy = main_valid + skid_valid, registered. Invariant: skid_valid implies main_valid.
- stall_count increments when out_valid & !out_ready and saturates at 2^CNT_W-1. Only rst clears it; flush does not.
- Reset mid-transfer: all held entries are discarded with no marker (out_flushed=0).

Test Plan:
- Streaming: out_ready=1, present 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, occupancy=1 throughout, in_ready=1 always.
- Backpressure/skid: out_ready=0, send 0xA then 0xB -> occupancy 1 then 2, in_ready=0 after 0xB. Raise out_ready -> 0xA then 0xB delivered in order, in_ready=1 one cycle after 0xA fires.
- Flush with full buffer: occupancy=2, assert flush with in_valid=1/in_data=0xC -> in_ready=0 that cycle. Next cycle out_valid=0, out_data=BUBBLE_VAL, out_flushed=1, occupancy=0. 0xC is never output.
- Stall counter saturation: CNT_W=3, hold out_valid=1/out_ready=0 for 10 cycles -> stall_count 1..7 then stays 7. Flush leaves it at 7; rst clears it to 0.
- Reset mid-operation: occupancy=2, assert rst one cycle -> all outputs at reset values, out_flushed=0. in_ready=1 on the first cycle after rst deasserts.
- Random valid/ready with periodic flush (10k cycles, scoreboard) -> in-order delivery of all non-flushed payloads, no duplicates, invariant skid_valid implies main_valid holds.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline register with 2-entry skid buffer, flush and stall counter
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   flush        synchronous kill of all held entries
//   in_valid     upstream payload valid
//   in_ready     stage can accept this cycle (registered skid state, gated by rst/flush)
//   in_data      upstream payload
//   out_valid    output entry valid
//   out_ready    downstream accepts this cycle
//   out_data     output payload, BUBBLE_VAL when out_valid=0
//   out_flushed  one-cycle marker, high the cycle after a flush
//   occupancy    entries held (0..2)
//   stall_count  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 128,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_flushed,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid, main_valid_n;
  logic [DATA_W-1:0] main_data,  main_data_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] skid_data,  skid_data_n;
  logic              flushed_q,  flushed_n;
  logic [1:0]        occ_q,      occ_n;
  logic [CNT_W-1:0]  stall_q,    stall_n;

  logic in_fire;
  logic out_fire;

  // Only rst/flush reach in_ready combinationally; skid_valid is a flop, so
  // no ready chain forms across consecutive stages.
  assign in_ready  = !rst && !flush && !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;

  // The main data register itself holds BUBBLE_VAL while empty, so out_data
  // comes straight from a flop with no output mux.
  assign out_valid   = main_valid;
  assign out_data    = main_data;
  assign out_flushed = flushed_q;
  assign occupancy   = occ_q;
  assign stall_count = stall_q;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    flushed_n    = 1'b0;
    stall_n      = stall_q;

    // Stall cycles are counted regardless of flush; only rst clears the count.
    if (main_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_n = stall_q + CNT_ONE;
    end

    if (flush) begin
      // A downstream out_fire in this cycle still completes; downstream owns
      // squashing it. Input is dropped because in_ready is low.
      main_valid_n = 1'b0;
      main_data_n  = BUBBLE_VAL;
      skid_valid_n = 1'b0;
      skid_data_n  = BUBBLE_VAL;
      flushed_n    = 1'b1;
    end else if (!main_valid) begin
      // Skid cannot be full while main is empty.
      if (in_fire) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        // Skid drains into main; in_fire is impossible here.
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
        skid_data_n  = BUBBLE_VAL;
      end else if (in_fire) begin
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
        main_data_n  = BUBBLE_VAL;
      end
    end else if (in_fire) begin
      // Main is stalled: park the new beat in the skid entry.
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end

    occ_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE_VAL;
      flushed_q  <= 1'b0;
      occ_q      <= 2'd0;
      stall_q    <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      flushed_q  <= flushed_n;
      occ_q      <= occ_n;
      stall_q    <= stall_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and scoreboarded checks for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] BUB = 8'hEE;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_flushed;
  logic [1:0]    occupancy;
  logic [2:0]    stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flushed(out_flushed), .occupancy(occupancy), .stall_count(stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [DW-1:0] d,
                             input logic [1:0] occ, input logic fl);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, ".out_data"}, 32'(out_data), 32'(d));
    check_eq({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    check_eq({tag, ".out_flushed"}, 32'(out_flushed), 32'(fl));
  endtask

  logic [DW-1:0] q[$];
  logic [2:0]    exp_stall;
  logic          exp_fl;
  logic          m_in_fire;
  logic          m_out_fire;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check_state("reset", 1'b0, BUB, 2'd0, 1'b0);
    check_eq("reset.stall", 32'(stall_count), 0);
    check_eq("reset.in_ready_in_rst", 32'(in_ready), 0);
    rst = 1'b0; #1;
    check_eq("reset.in_ready_after", 32'(in_ready), 1);

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    step(); check_state("stream0", 1'b1, 8'h11, 2'd1, 1'b0);
    in_data = 8'h22; #1; check_eq("stream.in_ready", 32'(in_ready), 1);
    step(); check_state("stream1", 1'b1, 8'h22, 2'd1, 1'b0);
    in_data = 8'h33; #1; check_eq("stream.in_ready2", 32'(in_ready), 1);
    step(); check_state("stream2", 1'b1, 8'h33, 2'd1, 1'b0);
    in_valid = 1'b0;
    step(); check_state("stream_drain", 1'b0, BUB, 2'd0, 1'b0);
    check_eq("stream.stall", 32'(stall_count), 0);

    // Backpressure into skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step(); check_state("bp0", 1'b1, 8'h0A, 2'd1, 1'b0);
    in_data = 8'h0B;
    step(); check_state("bp1", 1'b1, 8'h0A, 2'd2, 1'b0);
    in_valid = 1'b0; #1;
    check_eq("bp.in_ready_full", 32'(in_ready), 0);
    check_eq("bp.stall", 32'(stall_count), 1);
    out_ready = 1'b1;
    step(); check_state("bp2", 1'b1, 8'h0B, 2'd1, 1'b0);
    check_eq("bp.in_ready_after_fire", 32'(in_ready), 1);
    step(); check_state("bp3", 1'b0, BUB, 2'd0, 1'b0);

    // Flush with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
    step(); in_data = 8'h32;
    step(); check_eq("fl.occ_full", 32'(occupancy), 2);
    flush = 1'b1; in_data = 8'h0C; #1;
    check_eq("fl.in_ready", 32'(in_ready), 0);
    step(); flush = 1'b0; in_valid = 1'b0;
    check_state("fl0", 1'b0, BUB, 2'd0, 1'b1);
    check_eq("fl.stall", 32'(stall_count), 3);
    step(); check_state("fl1", 1'b0, BUB, 2'd0, 1'b0);
    // Back-to-back flush holds the marker
    flush = 1'b1;
    step(); check_eq("fl2.marker", 32'(out_flushed), 1);
    step(); check_eq("fl3.marker", 32'(out_flushed), 1);
    flush = 1'b0;
    step(); check_eq("fl4.marker", 32'(out_flushed), 0);

    // Stall counter saturation (CNT_W=3)
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("sat.cleared", 32'(stall_count), 0);
    in_valid = 1'b1; in_data = 8'h44;
    step(); in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_eq($sformatf("sat.cnt%0d", i), 32'(stall_count), (i > 7) ? 7 : i);
    end
    flush = 1'b1; step(); flush = 1'b0;
    check_eq("sat.after_flush", 32'(stall_count), 7);
    check_eq("sat.flushed", 32'(out_flushed), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("sat.after_rst", 32'(stall_count), 0);

    // Reset mid-operation
    in_valid = 1'b1; in_data = 8'h51;
    step(); in_data = 8'h52;
    step(); check_eq("mid.occ_full", 32'(occupancy), 2);
    in_valid = 1'b0; rst = 1'b1;
    step();
    check_state("mid_rst", 1'b0, BUB, 2'd0, 1'b0);
    check_eq("mid.stall", 32'(stall_count), 0);
    check_eq("mid.in_ready_in_rst", 32'(in_ready), 0);
    rst = 1'b0; #1;
    check_eq("mid.in_ready_after", 32'(in_ready), 1);

    // Random traffic against a queue model
    q.delete(); exp_stall = 3'd0; exp_fl = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      check_eq("rnd.in_ready", 32'(in_ready), 32'(!flush && q.size() < 2));
      check_eq("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      check_eq("rnd.out_data", 32'(out_data), 32'((q.size() > 0) ? q[0] : BUB));
      check_eq("rnd.occupancy", 32'(occupancy), 32'(q.size()));
      check_eq("rnd.out_flushed", 32'(out_flushed), 32'(exp_fl));
      check_eq("rnd.stall", 32'(stall_count), 32'(exp_stall));
      m_in_fire  = in_valid && !flush && (q.size() < 2);
      m_out_fire = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && exp_stall != 3'd7) exp_stall = exp_stall + 3'd1;
      exp_fl = flush;
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back(in_data);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
